// File: rtl/key_pkg.sv
// Shared definitions for the stopwatch key front-end.
// Holds the per-key channel state encoding and the key index map.
package key_pkg;

    localparam int NUM_KEYS    = 3;

    localparam int KEY_RESET   = 0;
    localparam int KEY_START   = 1;
    localparam int KEY_DISPLAY = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, debounce FSM with hold counter,
// and registered single-cycle press/release/long pulses.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic key_level
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_nxt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             long_nxt;
    logic             level_nxt;

    // Flops reset to 1 so a key held through reset still looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        hcnt_nxt  = hcnt;

        // Hold time keeps running through release bounces and saturates.
        if ((state == PRESSED || state == RELEASE_WAIT) && hcnt != LONG_MAX) begin
            hcnt_nxt = hcnt + CNT_ONE;
        end

        case (state)
            IDLE: begin
                hcnt_nxt = '0;
                if (!sync2) begin
                    state_nxt = PRESS_WAIT;
                    dcnt_nxt  = CNT_ONE;
                end else begin
                    dcnt_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync2) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = '0;
                    hcnt_nxt  = '0;
                end else begin
                    dcnt_nxt  = dcnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_nxt = RELEASE_WAIT;
                    dcnt_nxt  = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!sync2) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt  = dcnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
                hcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        press_nxt   = (state == PRESS_WAIT)   && !sync2 && (dcnt == DEB_LAST);
        release_nxt = (state == RELEASE_WAIT) &&  sync2 && (dcnt == DEB_LAST);
        long_nxt    = (state == PRESSED || state == RELEASE_WAIT) && (hcnt == LONG_LAST);
        level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            key_level     <= 1'b0;
        end else begin
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            key_level     <= level_nxt;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Stopwatch push-button front-end: one independent debounce channel per key.
// Bit 0 = reset key, bit 1 = start/pause key, bit 2 = display/stop key.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] key_level
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_n         (key_n[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .long_pulse    (long_pulse[k]),
            .key_level     (key_level[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, compared every cycle against a run-length reference model.
module tb_key_conditioner;
    import key_pkg::*;

    localparam int DEB = 4;
    localparam int LNG = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] long_pulse;
    logic [2:0] key_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: key_n delayed two samples, then a level flips after DEB
    // consecutive disagreeing samples; hold time counts edges while pressed.
    logic [2:0] m_d1, m_d2, m_level, m_press, m_release, m_long;
    int         m_run  [3];
    int         m_hold [3];

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .CNT_W           (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .key_level     (key_level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_d1      = 3'b111;
        m_d2      = 3'b111;
        m_level   = 3'b000;
        m_press   = 3'b000;
        m_release = 3'b000;
        m_long    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_run[i]  = 0;
            m_hold[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [2:0] kn);
        logic [2:0] s;
        s         = m_d2;
        m_d2      = m_d1;
        m_d1      = kn;
        m_press   = 3'b000;
        m_release = 3'b000;
        m_long    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            logic want;
            if (m_level[i] && m_hold[i] < LNG) begin
                m_hold[i]++;
                if (m_hold[i] == LNG) m_long[i] = 1'b1;
            end
            want = ~s[i];
            if (want != m_level[i]) m_run[i]++;
            else                    m_run[i] = 0;
            if (m_run[i] == DEB) begin
                m_run[i]   = 0;
                m_level[i] = want;
                if (want) begin
                    m_press[i] = 1'b1;
                    m_hold[i]  = 0;
                end else begin
                    m_release[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_bits(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_bits({tag, ".press"},   press_pulse,   m_press);
        check_bits({tag, ".release"}, release_pulse, m_release);
        check_bits({tag, ".long"},    long_pulse,    m_long);
        check_bits({tag, ".level"},   key_level,     m_level);
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] kn, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            key_n = kn;
            @(posedge clk);
            if (rst_n) model_edge(kn);
            #1;
            checkOutput(tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("in_reset");
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] kn;
        int         len;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        applyStimulus("idle", 3'b111, 10);

        // Clean press on the start key: pulse on the 6th edge sampling it low.
        applyStimulus("clean_press", 3'b101, 6);
        check_bits("clean_press_edge", press_pulse, 3'(1 << KEY_START));
        check_bits("clean_press_level", key_level, 3'(1 << KEY_START));

        // Two-sample release glitch must not release; long pulse 20 edges after press.
        applyStimulus("glitch_hold", 3'b101, 3);
        applyStimulus("glitch_high", 3'b111, 2);
        applyStimulus("glitch_back", 3'b101, 4);
        check_bits("glitch_level", key_level, 3'(1 << KEY_START));
        applyStimulus("glitch_long", 3'b101, 10);
        applyStimulus("glitch_long", 3'b101, 1);
        check_bits("glitch_long_edge", long_pulse, 3'(1 << KEY_START));
        applyStimulus("start_release", 3'b111, 6);
        check_bits("start_release_edge", release_pulse, 3'(1 << KEY_START));
        check_bits("start_release_level", key_level, 3'b000);

        // Bounce on the reset key never reaches DEB stable samples.
        applyStimulus("bounce", 3'b110, 3);
        applyStimulus("bounce", 3'b111, 1);
        applyStimulus("bounce", 3'b110, 3);
        applyStimulus("bounce", 3'b111, 8);
        check_bits("bounce_level", key_level, 3'b000);

        // Long press on the display key, 40 cycles total.
        applyStimulus("long_press", 3'b011, 6);
        check_bits("long_press_edge", press_pulse, 3'(1 << KEY_DISPLAY));
        applyStimulus("long_hold", 3'b011, 19);
        applyStimulus("long_hold", 3'b011, 1);
        check_bits("long_pulse_edge", long_pulse, 3'(1 << KEY_DISPLAY));
        applyStimulus("long_hold", 3'b011, 14);
        applyStimulus("long_release", 3'b111, 6);
        check_bits("long_release_edge", release_pulse, 3'(1 << KEY_DISPLAY));

        // Reset while start is pressed and the reset key is mid-debounce.
        applyStimulus("pre_reset", 3'b101, 6);
        applyStimulus("pre_reset", 3'b100, 3);
        do_reset();
        check_bits("reset_level", key_level, 3'b000);
        applyStimulus("post_reset", 3'b100, 6);
        check_bits("post_reset_press", press_pulse, 3'b011);
        applyStimulus("post_reset", 3'b111, 10);

        // All three keys fall on the same edge.
        applyStimulus("simultaneous", 3'b000, 6);
        check_bits("simultaneous_press", press_pulse, 3'b111);
        applyStimulus("simultaneous", 3'b111, 10);

        for (int seg = 0; seg < 500; seg++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                kn  = 3'($urandom);
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 30))
                                                  : int'($urandom_range(1, 7));
                applyStimulus("random", kn, len);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
